// File: rtl/axi_mem_pkg.sv
// Shared types for the AXI4-Lite emulation memory: response codes,
// address classification and the read-channel state encoding.
package axi_mem_pkg;

  typedef logic [1:0] axi_lite_resp_t;

  localparam axi_lite_resp_t RESP_OKAY   = 2'b00;
  localparam axi_lite_resp_t RESP_SLVERR = 2'b10;

  // What a bus address refers to.
  typedef enum logic [1:0] {
    KIND_RAM,
    KIND_CONS,
    KIND_ERR
  } addr_kind_t;

  // Read channel: accept address, sample RAM, present response.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SAMPLE,
    RD_RESP
  } rd_state_t;

  // Low two address bits never matter: all accesses are whole words.
  // The console register wins over the RAM window.
  function automatic addr_kind_t decode_addr(input logic [31:0] addr,
                                             input logic [31:0] cons_addr,
                                             input logic [31:0] mem_bytes);
    if ((addr & ~32'h3) == (cons_addr & ~32'h3)) return KIND_CONS;
    else if (addr < mem_bytes)                    return KIND_RAM;
    else                                          return KIND_ERR;
  endfunction

endpackage

// File: rtl/axi_lite_mem_model_if.sv
// AXI4-Lite slave bus plus the console byte stream that leaves the memory
// model towards the host-side sink.
interface axi_lite_mem_model_if;
  import axi_mem_pkg::*;

  logic           awvalid;
  logic           awready;
  logic [31:0]    awaddr;
  logic           wvalid;
  logic           wready;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           bvalid;
  logic           bready;
  axi_lite_resp_t bresp;
  logic           arvalid;
  logic           arready;
  logic [31:0]    araddr;
  logic           rvalid;
  logic           rready;
  logic [31:0]    rdata;
  axi_lite_resp_t rresp;
  logic           cons_valid;
  logic           cons_ready;
  logic [7:0]     cons_data;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, rready, cons_ready,
    output awready, wready, bvalid, bresp,
           arready, rvalid, rdata, rresp, cons_valid, cons_data
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
           arvalid, araddr, rready, cons_ready,
    input  awready, wready, bvalid, bresp,
           arready, rvalid, rdata, rresp, cons_valid, cons_data
  );

endinterface

// File: rtl/emu_byte_fifo.sv
// Small byte FIFO carrying console output to the host sink. Push and pop
// may happen in the same cycle; the extra pointer bit tells full from empty.
module emu_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = valid && ready;

  // Pointer update; the only state that reset has to clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately left out of reset; the pointers alone say
  // which entries are live, and a reset would stop RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_lite_mem_model.sv
// AXI4-Lite slave backing a DUT's memory port on the emulation side:
// word-organised byte-enabled RAM plus a write-only console register whose
// bytes drain through emu_byte_fifo. One read and one write in flight.
module axi_lite_mem_model
  import axi_mem_pkg::*;
#(
  parameter int          MEM_BYTES    = 65536,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int          CONS_DEPTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_mem_model_if.slave  s
);

  localparam int          WORDS     = MEM_BYTES / 4;
  localparam int          WORD_AW   = $clog2(WORDS);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  // Write channel state
  logic           aw_held;
  logic           w_held;
  logic [31:0]    aw_addr;
  logic [31:0]    w_data;
  logic [3:0]     w_strb;
  logic           bvalid_q;
  axi_lite_resp_t bresp_q;

  // Read channel state
  rd_state_t      rd_state;
  logic [31:0]    ar_addr;
  logic           arready_q;
  logic           rvalid_q;
  axi_lite_resp_t rresp_q;
  logic           rd_is_ram;
  logic [31:0]    ram_rd_q;

  // Decode and commit
  addr_kind_t     wr_kind;
  addr_kind_t     rd_kind;
  logic           fifo_full;
  logic           commit_ok;
  logic           commit;
  logic           cons_push;
  logic           ram_we;

  logic [31:0]    ram [WORDS];

  assign wr_kind   = decode_addr(aw_addr, CONSOLE_ADDR, MEM_LIMIT);
  assign rd_kind   = decode_addr(ar_addr, CONSOLE_ADDR, MEM_LIMIT);
  assign commit_ok = (wr_kind != KIND_CONS) || !fifo_full;
  assign commit    = aw_held && w_held && commit_ok;
  assign cons_push = commit && (wr_kind == KIND_CONS) && w_strb[0];
  assign ram_we    = commit && (wr_kind == KIND_RAM);

  assign s.awready = !aw_held && !bvalid_q;
  assign s.wready  = !w_held && !bvalid_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rd_is_ram ? ram_rd_q : '0;

  // Latch AW and W independently, commit once both are held, then respond.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (s.awvalid && s.awready) begin
        aw_held <= 1'b1;
        aw_addr <= s.awaddr;
      end
      if (s.wvalid && s.wready) begin
        w_held <= 1'b1;
        w_data <= s.wdata;
        w_strb <= s.wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_kind == KIND_ERR) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read FSM: address accepted, RAM sampled one edge later, response held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      ar_addr   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_is_ram <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s.arvalid) begin
            ar_addr   <= s.araddr;
            arready_q <= 1'b0;
            rd_state  <= RD_SAMPLE;
          end
        end
        RD_SAMPLE: begin
          rvalid_q  <= 1'b1;
          rresp_q   <= (rd_kind == KIND_ERR) ? RESP_SLVERR : RESP_OKAY;
          rd_is_ram <= (rd_kind == KIND_RAM);
          rd_state  <= RD_RESP;
        end
        RD_RESP: begin
          if (s.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          rd_state  <= RD_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled RAM port. A sample and a commit on the same edge to the
  // same word return the old contents (read-before-write).
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) ram[aw_addr[WORD_AW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
    if (rd_state == RD_SAMPLE) ram_rd_q <= ram[ar_addr[WORD_AW+1:2]];
  end

  // Console byte path towards the host sink.
  emu_byte_fifo #(
    .DEPTH (CONS_DEPTH)
  ) u_cons_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cons_push),
    .push_data (w_data[7:0]),
    .full      (fifo_full),
    .valid     (s.cons_valid),
    .ready     (s.cons_ready),
    .data      (s.cons_data)
  );

endmodule
